// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM encoding and one-hot helper for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  function automatic logic [NREQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v = NREQ'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping modulo 8.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [NREQ-1:0]  onehot
);

  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] off;

  // rot[0] is the requester at ptr, so a plain lowest-bit search gives the rotated priority
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [IDX_W-1:0] src;
      assign src     = IDX_W'(gi) + ptr;
      assign rot[gi] = req[src];
    end
  endgenerate

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign any    = |req;
  assign idx    = ptr + off;
  assign onehot = any ? onehot8(idx) : '0;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and valid/ready handshake.
// Optional ARB_LOCK_EN adds a lock input that keeps the pointer on the granted index.
module rr_arbiter8
  import rr_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            gnt_ready,
`ifdef ARB_LOCK_EN
  input  logic            lock,
`endif
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid
);

  arb_state_e       state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] gidx_reg;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [NREQ-1:0]  pick_onehot;
  logic             handshake;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign handshake = (state_reg == OFFER) && gnt_valid && gnt_ready;

  always_comb begin
    ptr_next = gidx_reg + IDX_W'(1);
`ifdef ARB_LOCK_EN
    if (lock) ptr_next = gidx_reg;
`endif
  end

  // req is only looked at in IDLE, so the offered grant stays sticky under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      gidx_reg  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            gnt       <= pick_onehot;
            gnt_valid <= 1'b1;
            gidx_reg  <= pick_idx;
            state_reg <= OFFER;
          end else begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end
        end
        OFFER: begin
          if (handshake) begin
            ptr_reg   <= ptr_next;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: expected grants are queued as stimulus is driven
// and popped when a new grant appears; ARB_LOCK_EN enables the lock scenario.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic       gnt_ready;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_gnt;
  logic       prev_valid = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter8 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt_ready (gnt_ready),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic v);
    check_val({tag, "_gnt"}, 32'(gnt), 32'(g));
    check_val({tag, "_vld"}, 32'(gnt_valid), 32'(v));
  endtask

  // Monitor: structural invariants every cycle, scoreboard pop on each new grant
  always @(negedge clk) begin
    check_val("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (!gnt_valid) check_val("idle_zero", 32'(gnt), 32'd0);
    if (gnt_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check_val("sb_underflow", 32'(gnt), 32'd0);
      end else begin
        exp_gnt = exp_q.pop_front();
        $display("txn grant gnt=%02h exp=%02h t=%0t", gnt, exp_gnt, $time);
        check_val("grant", 32'(gnt), 32'(exp_gnt));
      end
    end
    prev_valid = gnt_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req       = 8'hFF;
    gnt_ready = 1'b0;
`ifdef ARB_LOCK_EN
    lock      = 1'b0;
`endif
    for (int c = 0; c < 2; c++) begin
      tick();
      expect_out("rst", 8'h00, 1'b0);
    end

    // Rotation: 01..80 then 01, one grant every 2 cycles
    rst       = 1'b0;
    gnt_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp_gnt = 8'h01 << (k % 8);
      exp_q.push_back(exp_gnt);
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      check_val("rot_vld1", 32'(gnt_valid), 32'd1);
      tick();
      check_val("rot_vld0", 32'(gnt_valid), 32'd0);
    end
    req = 8'h00;

    // Skip and wrap: grant index 5 leaves ptr=6, then req=09 wraps to index 0, then 3
    req = 8'h20;
    exp_q.push_back(8'h20);
    tick();
    tick();
    req = 8'h09;
    exp_q.push_back(8'h01);
    tick();
    expect_out("wrap", 8'h01, 1'b1);
    tick();
    exp_q.push_back(8'h08);
    tick();
    expect_out("skip", 8'h08, 1'b1);
    req = 8'h00;
    tick();
    expect_out("wrap_done", 8'h00, 1'b0);

    // Backpressure: grant held stable, req dropped mid-offer
    gnt_ready = 1'b0;
    req       = 8'h10;
    exp_q.push_back(8'h10);
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req = 8'h00;
      tick();
      expect_out("bp", 8'h10, 1'b1);
    end
    gnt_ready = 1'b1;
    tick();
    expect_out("bp_hs", 8'h00, 1'b0);

    // ptr must now be 5
    req       = 8'hFF;
    gnt_ready = 1'b0;
    exp_q.push_back(8'h20);
    tick();
    expect_out("ptr5", 8'h20, 1'b1);
    gnt_ready = 1'b1;
    tick();

    // Reset mid-offer discards the pending grant and clears ptr
    req       = 8'h04;
    gnt_ready = 1'b0;
    exp_q.push_back(8'h04);
    tick();
    expect_out("pend", 8'h04, 1'b1);
    rst = 1'b1;
    tick();
    expect_out("rst_mid", 8'h00, 1'b0);
    rst       = 1'b0;
    req       = 8'hFF;
    gnt_ready = 1'b1;
    exp_q.push_back(8'h01);
    tick();
    expect_out("ptr0", 8'h01, 1'b1);
    req = 8'h00;
    tick();
    expect_out("ptr0_hs", 8'h00, 1'b0);

`ifdef ARB_LOCK_EN
    req       = 8'h06;
    lock      = 1'b1;
    gnt_ready = 1'b0;
    exp_q.push_back(8'h02);
    tick();
    gnt_ready = 1'b1;
    tick();
    exp_q.push_back(8'h02);
    tick();
    expect_out("lock_again", 8'h02, 1'b1);
    lock = 1'b0;
    tick();
    exp_q.push_back(8'h04);
    tick();
    expect_out("lock_next", 8'h04, 1'b1);
    req = 8'h00;
    tick();
`endif

    tick();
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
